write_back_stage: RTL and testbench

Final pipeline stage of the RV32 core: accepts one instruction per handshake from the memory stage, along with the write-back control produced by decode (register-file write params and write-back select). It selects the result source (ALU, formatted load data, or PC+4) and drives the register-file write port plus a matching forwarding bus. It also maintains the retired-instruction counter. Loads stall the stage in a wait state until the data-memory response arrives.

---
 rtl/write_back_stage.sv | 89 ++++++++
 tb/tb_write_back_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// write_back_stage: RV32 write-back with load wait state, forwarding copy and instret counter.
// in_sel encoding: 0 = ALU, 1 = MEM, 2 = PC (3 behaves as ALU).
module write_back_stage #(
  parameter int XLEN          = 32,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_write_enable,
  input  logic [4:0]               in_addr_rd,
  input  logic [1:0]               in_sel,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [2:0]               in_funct3,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [XLEN-1:0]          rf_data,
  output logic                     fwd_valid,
  output logic [4:0]               fwd_addr,
  output logic [XLEN-1:0]          fwd_data,
  output logic                     retire,
  output logic [INSTRET_WIDTH-1:0] instret
);
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t      state_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic        accept, retire_d, wb_we;
  logic [4:0]  wb_rd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [XLEN-1:0] ld_data, wb_data;
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  // Loads retire from the latched packet; everything else retires straight from the inputs.
  always_comb begin
    lb       = mem_rsp_data[8*a_q +: 8];
    lh       = a_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    ld_data  = f3_q[1:0] == 2'b00 ? {{(XLEN-8){~f3_q[2] & lb[7]}}, lb}
             : f3_q[1:0] == 2'b01 ? {{(XLEN-16){~f3_q[2] & lh[15]}}, lh}
             : mem_rsp_data;
    retire_d = state_q == WAIT_MEM ? mem_rsp_valid : accept && in_sel != SEL_MEM;
    wb_we    = state_q == WAIT_MEM ? we_q : in_write_enable;
    wb_rd    = state_q == WAIT_MEM ? rd_q : in_addr_rd;
    wb_data  = state_q == WAIT_MEM ? ld_data
             : in_sel == SEL_PC ? in_pc + XLEN'(4) : in_alu_result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      rd_q    <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      retire  <= 1'b0;
      instret <= '0;
    end else begin
      if (accept) begin
        we_q <= in_write_enable;
        rd_q <= in_addr_rd;
        f3_q <= in_funct3;
        a_q  <= in_alu_result[1:0];
        if (in_sel == SEL_MEM) state_q <= WAIT_MEM;
      end
      if (state_q == WAIT_MEM && mem_rsp_valid) state_q <= IDLE;
      rf_we  <= retire_d && wb_we && |wb_rd;
      retire <= retire_d;
      if (retire_d) begin
        rf_addr <= wb_rd;
        rf_data <= wb_data;
        instret <= instret + INSTRET_WIDTH'(1);
      end
    end
  end
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_addr;
  assign fwd_data  = rf_data;
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: directed vector bench for write_back_stage, with a 3-bit instret twin for wrap.
module tb_write_back_stage;
  logic        clk = 0, reset, in_valid, in_write_enable, mem_rsp_valid;
  logic [4:0]  in_addr_rd;
  logic [1:0]  in_sel;
  logic [31:0] in_alu_result, in_pc, mem_rsp_data;
  logic [2:0]  in_funct3;
  logic        in_ready, rf_we, fwd_valid, retire;
  logic [4:0]  rf_addr, fwd_addr;
  logic [31:0] rf_data, fwd_data;
  logic [63:0] instret;
  logic        s_ready, s_we, s_fv, s_ret;
  logic [4:0]  s_addr, s_fa;
  logic [31:0] s_data, s_fd;
  logic [2:0]  s_instret;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] exp_ir;
  always #5 clk = ~clk;
  write_back_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_write_enable(in_write_enable), .in_addr_rd(in_addr_rd), .in_sel(in_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retire(retire), .instret(instret));
  write_back_stage #(.INSTRET_WIDTH(3)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready),
    .in_write_enable(in_write_enable), .in_addr_rd(in_addr_rd), .in_sel(in_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(s_we), .rf_addr(s_addr), .rf_data(s_data),
    .fwd_valid(s_fv), .fwd_addr(s_fa), .fwd_data(s_fd),
    .retire(s_ret), .instret(s_instret));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input logic ret);
    chk({tag, " rf_we"}, 64'(rf_we), 64'(we));
    chk({tag, " rf_addr"}, 64'(rf_addr), 64'(addr));
    chk({tag, " rf_data"}, 64'(rf_data), 64'(data));
    chk({tag, " retire"}, 64'(retire), 64'(ret));
    chk({tag, " fwd"}, {fwd_valid, fwd_addr, fwd_data}, {rf_we, rf_addr, rf_data});
    chk({tag, " instret"}, instret, exp_ir);
    chk({tag, " instret_w3"}, 64'(s_instret), 64'(exp_ir[2:0]));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic v, we; logic [4:0] rd; logic [1:0] sel; logic [31:0] alu, pc;
    logic ewe; logic [4:0] ea; logic [31:0] ed;
  } vec_t;
  typedef struct {
    logic [2:0] f3; logic [31:0] addr, data; int dly; logic [4:0] rd; logic ewe; logic [31:0] ed;
  } ld_t;
  vec_t tv[9];
  ld_t  lv[9];
  initial begin
    tv[0] = '{1, 1, 5,  0, 32'h12345678, 32'h0,        1, 5,  32'h12345678};
    tv[1] = '{0, 1, 9,  0, 32'hAAAAAAAA, 32'h0,        0, 5,  32'h12345678};
    tv[2] = '{1, 1, 0,  0, 32'h11,       32'h0,        0, 0,  32'h11};
    tv[3] = '{1, 1, 0,  0, 32'h22,       32'h0,        0, 0,  32'h22};
    tv[4] = '{1, 1, 0,  0, 32'h33,       32'h0,        0, 0,  32'h33};
    tv[5] = '{1, 0, 7,  0, 32'hDEAD,     32'h0,        0, 7,  32'hDEAD};
    tv[6] = '{1, 1, 1,  2, 32'h55,       32'hFFFFFFFC, 1, 1,  32'h0};
    tv[7] = '{1, 1, 31, 2, 32'h0,        32'h100,      1, 31, 32'h104};
    tv[8] = '{1, 1, 3,  3, 32'hCAFEF00D, 32'h200,      1, 3,  32'hCAFEF00D};
    lv[0] = '{3'b000, 32'h1002, 32'h80FF7F01, 3, 4,  1, 32'hFFFFFFFF};
    lv[1] = '{3'b100, 32'h1002, 32'h80FF7F01, 3, 4,  1, 32'h000000FF};
    lv[2] = '{3'b001, 32'h1002, 32'h80FF7F01, 2, 6,  1, 32'hFFFF80FF};
    lv[3] = '{3'b101, 32'h1003, 32'h80FF7F01, 1, 6,  1, 32'h000080FF};
    lv[4] = '{3'b000, 32'h1003, 32'h80FF7F01, 1, 8,  1, 32'hFFFFFF80};
    lv[5] = '{3'b000, 32'h1001, 32'h80FF7F01, 1, 8,  1, 32'h0000007F};
    lv[6] = '{3'b001, 32'h1000, 32'h80FF7F01, 1, 8,  1, 32'h00007F01};
    lv[7] = '{3'b011, 32'h1001, 32'h80FF7F01, 2, 9,  1, 32'h80FF7F01};
    lv[8] = '{3'b010, 32'h1000, 32'h13572468, 1, 0,  0, 32'h13572468};
    reset = 1; in_valid = 0; in_write_enable = 0; in_addr_rd = 0; in_sel = 0;
    in_alu_result = 0; in_pc = 0; in_funct3 = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    exp_ir = 0;
    tick; tick;
    chk("ready in reset", 64'(in_ready), 0);
    check_out("reset", 0, 0, 0, 0);
    reset = 0;
    #1;
    chk("ready after reset", 64'(in_ready), 1);
    for (int i = 0; i < 9; i++) begin
      in_valid = tv[i].v; in_write_enable = tv[i].we; in_addr_rd = tv[i].rd;
      in_sel = tv[i].sel; in_alu_result = tv[i].alu; in_pc = tv[i].pc;
      chk($sformatf("vec%0d ready", i), 64'(in_ready), 1);
      tick;
      in_valid = 0;
      if (tv[i].v) exp_ir++;
      check_out($sformatf("vec%0d", i), tv[i].ewe, tv[i].ea, tv[i].ed, tv[i].v);
    end
    tick;
    check_out("idle after vec", 0, 3, 32'hCAFEF00D, 0);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_write_enable = 1; in_addr_rd = lv[i].rd; in_sel = 1;
      in_alu_result = lv[i].addr; in_funct3 = lv[i].f3; mem_rsp_data = lv[i].data;
      tick;
      in_valid = 0;
      for (int k = 0; k < lv[i].dly; k++) begin
        chk($sformatf("ld%0d wait ready", i), 64'(in_ready), 0);
        chk($sformatf("ld%0d wait we", i), 64'(rf_we | retire), 0);
        if (k == lv[i].dly - 1) mem_rsp_valid = 1;
        tick;
      end
      mem_rsp_valid = 0;
      exp_ir++;
      check_out($sformatf("ld%0d", i), lv[i].ewe, lv[i].rd, lv[i].ed, 1);
      chk($sformatf("ld%0d ready", i), 64'(in_ready), 1);
      tick;
      chk($sformatf("ld%0d clear", i), 64'(rf_we | retire), 0);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'hFFFFFFFF;
    tick;
    mem_rsp_valid = 0;
    check_out("stray rsp", 0, 0, 32'h13572468, 0);
    in_valid = 1; in_write_enable = 1; in_addr_rd = 12; in_sel = 1; in_funct3 = 3'b010;
    tick;
    in_valid = 0;
    tick;
    reset = 1;
    #1;
    chk("ready during reset", 64'(in_ready), 0);
    tick;
    reset = 0; exp_ir = 0;
    mem_rsp_valid = 1;
    tick;
    mem_rsp_valid = 0;
    check_out("abandoned load", 0, 0, 0, 0);
    chk("ready after abandon", 64'(in_ready), 1);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_write_enable = 1; in_addr_rd = 5'(i + 1); in_sel = 0;
      in_alu_result = 32'(i * 3);
      tick;
      exp_ir++;
      check_out($sformatf("wrap%0d", i), 1, 5'(i + 1), 32'(i * 3), 1);
    end
    in_valid = 0;
    chk("w3 wrapped", 64'(s_instret), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
